// File: rtl/audio_pkg.sv
// Shared audio definitions: note codes, envelope states and the 10 MHz half-period table.
package audio_pkg;

    typedef enum logic [3:0] {
        TONE_C    = 4'h0,
        TONE_CS   = 4'h1,
        TONE_D    = 4'h2,
        TONE_DS   = 4'h3,
        TONE_E    = 4'h4,
        TONE_F    = 4'h5,
        TONE_FS   = 4'h6,
        TONE_G    = 4'h7,
        TONE_GS   = 4'h8,
        TONE_A    = 4'h9,
        TONE_AS   = 4'hA,
        TONE_B    = 4'hB,
        TONE_C_HI = 4'hC,
        TONE_OFF  = 4'hF
    } tone_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } env_state_t;

    localparam int HP_W = 17;

    // Half a period of each note, in 10 MHz clock cycles.
    localparam logic [HP_W-1:0] HALF_PERIOD [0:12] = '{
        17'd19111, 17'd18039, 17'd17026, 17'd16071, 17'd15169, 17'd14317, 17'd13514,
        17'd12755, 17'd12039, 17'd11364, 17'd10726, 17'd10124, 17'd9556
    };

    // Codes above high C (0xD, 0xE, 0xF) all mean silence.
    function automatic tone_t normalise(input logic [3:0] code);
        return (code > 4'hC) ? TONE_OFF : tone_t'(code);
    endfunction

endpackage

// File: rtl/tone_envelope.sv
// Attack/decay/sustain/release envelope: owns the state machine and the 8-bit amplitude.
module tone_envelope
    import audio_pkg::*;
#(
    parameter logic [7:0] SUSTAIN_LVL  = 8'd96,
    parameter logic [7:0] DECAY_STEP   = 8'd1,
    parameter logic [7:0] RELEASE_STEP = 8'd4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       note_start,
    input  logic       note_stop,
    input  logic       clkdiv,
    output logic [7:0] amp,
    output env_state_t state,
    output logic       release_done
);

    localparam logic [8:0] DECAY_FLOOR = 9'(SUSTAIN_LVL) + 9'(DECAY_STEP);

    env_state_t state_next;
    logic [7:0] amp_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            amp   <= 8'd0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            state <= state_next;
            amp   <= amp_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_next = state;
        amp_next   = amp;
        if (note_start) begin
            // A new note beats a coincident envelope tick.
            state_next = PLAY;
            amp_next   = 8'hFF;
        end else begin
            case (state)
                PLAY: begin
                    if (note_stop) begin
                        state_next = RELEASE;
                    end else if (clkdiv) begin
                        amp_next = ({1'b0, amp} >= DECAY_FLOOR) ? amp - DECAY_STEP : SUSTAIN_LVL;
                    end
                end
                RELEASE: begin
                    if (clkdiv) begin
                        if (amp <= RELEASE_STEP) begin
                            amp_next   = 8'd0;
                            state_next = IDLE;
                        end else begin
                            amp_next = amp - RELEASE_STEP;
                        end
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_comb begin
        release_done = (state == RELEASE) && clkdiv && !note_start && (amp <= RELEASE_STEP);
    end

endmodule

// File: rtl/note_tone_gen.sv
// Note-code to speaker PWM: square wave at the note pitch, gated by an 8-bit envelope PWM.
module note_tone_gen
    import audio_pkg::*;
#(
    parameter logic [7:0] SUSTAIN_LVL  = 8'd96,
    parameter logic [7:0] DECAY_STEP   = 8'd1,
    parameter logic [7:0] RELEASE_STEP = 8'd4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] note_in,
    input  logic       clkdiv,
    output logic       square_out,
    output logic       pwm_out,
    output logic [7:0] amp,
    output logic       active
);

    tone_t            note_norm;
    tone_t            cur_note;
    logic             note_start;
    logic             note_stop;
    logic [HP_W-1:0]  half_period;
    logic [HP_W-1:0]  period_cnt;
    logic [7:0]       pwm_cnt;
    env_state_t       state;
    logic             release_done;

    assign note_norm  = normalise(note_in);
    assign note_start = (note_norm != cur_note) && (note_norm != TONE_OFF);
    assign note_stop  = (note_norm != cur_note) && (note_norm == TONE_OFF);
    assign active     = (state != IDLE);

    tone_envelope #(
        .SUSTAIN_LVL  (SUSTAIN_LVL),
        .DECAY_STEP   (DECAY_STEP),
        .RELEASE_STEP (RELEASE_STEP)
    ) u_envelope (
        .clk          (clk),
        .n_rst        (n_rst),
        .note_start   (note_start),
        .note_stop    (note_stop),
        .clkdiv       (clkdiv),
        .amp          (amp),
        .state        (state),
        .release_done (release_done)
    );

    // half_period is only reloaded by a valid note, so the tone keeps its pitch through release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_note    <= TONE_OFF;
            half_period <= '0;
        end else begin
            cur_note <= note_norm;
            if (note_start) begin
                half_period <= HALF_PERIOD[4'(note_norm)];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            period_cnt <= '0;
            square_out <= 1'b0;
        end else if (note_start) begin
            period_cnt <= '0;
            square_out <= 1'b0;
        end else if (state == IDLE || release_done) begin
            period_cnt <= '0;
            square_out <= 1'b0;
        end else if (period_cnt == half_period - 17'd1) begin
            period_cnt <= '0;
            square_out <= ~square_out;
        end else begin
            period_cnt <= period_cnt + 17'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pwm_cnt <= 8'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_out <= square_out & (pwm_cnt < amp);
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: pitch timing, envelope shape, retrigger and reset behaviour.
module tb_note_tone_gen;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] note_in = 4'hF;
    logic       clkdiv = 1'b0;
    logic       square_out;
    logic       pwm_out;
    logic [7:0] amp;
    logic       active;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;

    note_tone_gen dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .note_in    (note_in),
        .clkdiv     (clkdiv),
        .square_out (square_out),
        .pwm_out    (pwm_out),
        .amp        (amp),
        .active     (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        clkdiv = 1'b1;
        tick();
        clkdiv = 1'b0;
        tick();
    endtask

    // Returns the cycle stamp at which square_out reached lvl, or -1 if the budget ran out.
    task automatic wait_sq(input logic lvl, input int budget, output int stamp);
        int n = 0;
        while (square_out !== lvl && n < budget) begin
            tick();
            n++;
        end
        stamp = (square_out === lvl) ? cyc : -1;
    endtask

    task automatic count_pwm(input int len, output int highs);
        highs = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({square_out, pwm_out, amp, active} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got sq=%b pwm=%b amp=%0d act=%b, want all 0",
                     square_out, pwm_out, amp, active);
        end
        n_rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({square_out, amp, active} !== 10'd0) begin
            errors++;
            $display("FAIL reset_idle: got sq=%b amp=%0d act=%b, want all 0", square_out, amp, active);
        end
    endtask

    task automatic test_note_a();
        int cap;
        int stamp;
        note_in = 4'h9;
        tick();
        cap = cyc;
        checks++;
        if (amp !== 8'd255 || active !== 1'b1 || square_out !== 1'b0) begin
            errors++;
            $display("FAIL a_capture: got amp=%0d act=%b sq=%b, want 255 1 0", amp, active, square_out);
        end
        wait_sq(1'b1, 12000, stamp);
        checks++;
        if (stamp - cap !== 11364) begin
            errors++;
            $display("FAIL a_first_rise: got %0d cycles, want 11364", stamp - cap);
        end
        rise_cyc = stamp;
    endtask

    task automatic test_sustain();
        int exp_amp;
        for (int k = 1; k <= 200; k++) begin
            pulse();
            exp_amp = (255 - k > 96) ? 255 - k : 96;
            checks++;
            if (amp !== 8'(exp_amp)) begin
                errors++;
                $display("FAIL decay_pulse_%0d: got amp=%0d, want %0d", k, amp, exp_amp);
            end
        end
    endtask

    task automatic test_release();
        int stamp;
        int highs;
        wait_sq(1'b0, 12000, stamp);
        checks++;
        if (stamp - rise_cyc !== 11364) begin
            errors++;
            $display("FAIL a_high_half: got %0d cycles, want 11364", stamp - rise_cyc);
        end
        note_in = 4'hF;
        tick();
        checks++;
        if (active !== 1'b1 || amp !== 8'd96) begin
            errors++;
            $display("FAIL off_enter: got act=%b amp=%0d, want 1 96", active, amp);
        end
        wait_sq(1'b1, 12000, stamp);
        checks++;
        if (stamp - rise_cyc !== 22728) begin
            errors++;
            $display("FAIL release_period: got %0d cycles, want 22728", stamp - rise_cyc);
        end
        count_pwm(256, highs);
        checks++;
        if (highs !== 96) begin
            errors++;
            $display("FAIL pwm_duty96: got %0d high cycles of 256, want 96", highs);
        end
        for (int k = 1; k <= 23; k++) pulse();
        checks++;
        if (amp !== 8'd4 || active !== 1'b1 || square_out !== 1'b1) begin
            errors++;
            $display("FAIL release_23: got amp=%0d act=%b sq=%b, want 4 1 1", amp, active, square_out);
        end
        clkdiv = 1'b1;
        tick();
        clkdiv = 1'b0;
        checks++;
        if (amp !== 8'd0 || active !== 1'b0 || square_out !== 1'b0) begin
            errors++;
            $display("FAIL release_end: got amp=%0d act=%b sq=%b, want 0 0 0", amp, active, square_out);
        end
    endtask

    task automatic test_silent_and_repeat();
        int highs;
        note_in = 4'hD;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (active !== 1'b0 || amp !== 8'd0 || square_out !== 1'b0) begin
            errors++;
            $display("FAIL code_d_silent: got act=%b amp=%0d sq=%b, want 0 0 0", active, amp, square_out);
        end
        note_in = 4'hE;
        count_pwm(260, highs);
        checks++;
        if (active !== 1'b0 || amp !== 8'd0 || highs !== 0) begin
            errors++;
            $display("FAIL code_e_silent: got act=%b amp=%0d pwm_high=%0d, want 0 0 0", active, amp, highs);
        end
        note_in = 4'h4;
        tick();
        checks++;
        if (amp !== 8'd255 || active !== 1'b1) begin
            errors++;
            $display("FAIL e_capture: got amp=%0d act=%b, want 255 1", amp, active);
        end
        for (int k = 0; k < 10; k++) begin
            note_in = 4'h4;
            pulse();
        end
        checks++;
        if (amp !== 8'd245 || active !== 1'b1) begin
            errors++;
            $display("FAIL repeat_no_retrigger: got amp=%0d act=%b, want 245 1", amp, active);
        end
    endtask

    task automatic test_retrigger();
        int cap;
        int stamp;
        for (int k = 0; k < 149; k++) pulse();
        checks++;
        if (amp !== 8'd96) begin
            errors++;
            $display("FAIL e_sustain: got amp=%0d, want 96", amp);
        end
        note_in = 4'hF;
        tick();
        for (int k = 0; k < 14; k++) pulse();
        checks++;
        if (amp !== 8'd40 || active !== 1'b1) begin
            errors++;
            $display("FAIL release_40: got amp=%0d act=%b, want 40 1", amp, active);
        end
        note_in = 4'h0;
        clkdiv = 1'b1;
        tick();
        clkdiv = 1'b0;
        cap = cyc;
        checks++;
        if (amp !== 8'd255 || active !== 1'b1 || square_out !== 1'b0) begin
            errors++;
            $display("FAIL retrigger_wins: got amp=%0d act=%b sq=%b, want 255 1 0", amp, active, square_out);
        end
        wait_sq(1'b1, 20000, stamp);
        checks++;
        if (stamp - cap !== 19111) begin
            errors++;
            $display("FAIL c_first_rise: got %0d cycles, want 19111", stamp - cap);
        end
    endtask

    task automatic test_reset_mid_note();
        int cap;
        int stamp;
        checks++;
        if (square_out !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got sq=%b act=%b, want 1 1", square_out, active);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({square_out, pwm_out, amp, active} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got sq=%b pwm=%b amp=%0d act=%b, want all 0",
                     square_out, pwm_out, amp, active);
        end
        note_in = 4'hC;
        #2;
        n_rst = 1'b1;
        tick();
        cap = cyc;
        checks++;
        if (amp !== 8'd255 || active !== 1'b1) begin
            errors++;
            $display("FAIL hi_c_capture: got amp=%0d act=%b, want 255 1", amp, active);
        end
        wait_sq(1'b1, 10000, stamp);
        checks++;
        if (stamp - cap !== 9556) begin
            errors++;
            $display("FAIL hi_c_first_rise: got %0d cycles, want 9556", stamp - cap);
        end
    endtask

    initial begin
        test_reset();
        test_note_a();
        test_sustain();
        test_release();
        test_silent_and_repeat();
        test_retrigger();
        test_reset_mid_note();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
